// File: rtl/alu_arbiter_16.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin arbitration, a registered operand stage that drives the ALU, and a
// registered valid/ready response carrying the result, requester id and an error flag.
module alu_arbiter_16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_s,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OpIllegal = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic               rr_q, rr_d;
    logic               id_q, id_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               grant;
    logic               accept;

    // Arbitration: a lone requester wins; on a tie the RR pointer decides.
    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        grant      = (req0_valid & req1_valid) ? rr_q : req1_valid;
        accept     = rst_n & (state_q == StIdle) & (req0_valid | req1_valid);
        req0_ready = accept & ~grant;
        req1_ready = accept & grant;
    end

    // Next-state logic: operand capture, result capture and response handshake.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    id_d     = grant;
                    alu_op_d = grant ? req1_op : req0_op;
                    alu_a_d  = grant ? req1_a  : req0_a;
                    alu_b_d  = grant ? req1_b  : req0_b;
                    state_d  = StExec;
                end
            end
            StExec: begin
                rsp_err_d  = (alu_op_q == OpIllegal);
                rsp_data_d = (alu_op_q == OpIllegal) ? '0 : alu_s;
                rsp_id_d   = id_q;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    // Hand the next tie to whoever was not just served.
                    rr_d    = ~rsp_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            id_q       <= 1'b0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Output drive straight from registers.
    always_comb begin
        alu_op    = alu_op_q;
        alu_a     = alu_a_q;
        alu_b     = alu_b_q;
        rsp_valid = (state_q == StResp);
        rsp_id    = rsp_id_q;
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        op_count  = cnt_q;
    end

endmodule
